// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the framed UART sample transmitter.
// Holds the framer state encoding, 8N1 bit-time constants and the LEN helper.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_PAY_HI,
    ST_PAY_LO,
    ST_CHK
  } frame_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // 8N1: start + 8 data + stop
  localparam int         BITS_PER_BYTE = 10;
  localparam logic [3:0] STOP_BIT_IDX  = 4'(BITS_PER_BYTE - 1);

  // LEN byte carries the payload size in bytes (two per 16-bit sample).
  function automatic logic [7:0] frame_len(input int unsigned samples);
    return 8'(2 * samples);
  endfunction

endpackage

// File: rtl/uart_byte_ser.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each BIT_COUNT cycles.
// The idle cycle after the shift phase doubles as the last stop-bit cycle, so bytes chain gaplessly.
module uart_byte_ser
  import uart_pkt_pkg::*;
#(
  parameter logic [9:0] BIT_COUNT = 10'd868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  ser_state_t  state, state_next;
  logic [8:0]  shreg;
  logic [3:0]  bit_idx;
  logic [9:0]  tick;
  logic        bit_end;
  logic        frame_end;

  assign bit_end    = (tick == BIT_COUNT - 10'd1);
  assign frame_end  = (bit_idx == STOP_BIT_IDX) && (tick == BIT_COUNT - 10'd2);
  assign byte_ready = (state == SER_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      SER_IDLE:  if (byte_valid) state_next = SER_SHIFT;
      SER_SHIFT: if (frame_end)  state_next = SER_IDLE;
      default:   state_next = SER_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SER_IDLE;
      tx      <= 1'b1;
      shreg   <= '1;
      bit_idx <= '0;
      tick    <= '0;
    end else begin
      state <= state_next;
      if (state == SER_IDLE) begin
        if (byte_valid) begin
          tx      <= 1'b0;
          shreg   <= {1'b1, byte_in};
          bit_idx <= '0;
          tick    <= '0;
        end
      end else if (bit_end) begin
        tick    <= '0;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_idx <= bit_idx + 4'd1;
      end else begin
        tick <= tick + 10'd1;
      end
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// Framed UART transmitter: sample FIFO feeding SYNC, LEN, payload (MSB first) packets.
// Define UART_PACKET_TX_CHECKSUM_EN to append an XOR checksum of LEN and payload bytes.
module uart_packet_tx
  import uart_pkt_pkg::*;
#(
  parameter logic [9:0] BIT_COUNT         = 10'd868,
  parameter int         FIFO_DEPTH        = 16,
  parameter int         SAMPLES_PER_FRAME = 4,
  parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int               PTR_W       = $clog2(FIFO_DEPTH);
  localparam int               CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FRAME_CNT   = CNT_W'(SAMPLES_PER_FRAME);
  localparam logic [6:0]       LAST_SAMPLE = 7'(SAMPLES_PER_FRAME - 1);
  localparam logic [7:0]       LEN_BYTE    = frame_len(SAMPLES_PER_FRAME);

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic [15:0]      head;

  frame_state_t state, state_next;
  logic [6:0]   sent;
  logic [7:0]   byte_data;
  logic         byte_valid, byte_ready;
`ifdef UART_PACKET_TX_CHECKSUM_EN
  logic [7:0]   checksum;
`endif

  // Ready comes from the registered count, so a write coinciding with a pop while full is refused.
  assign sample_ready = (count != FULL_CNT);
  assign push         = sample_valid && sample_ready;
  assign head         = mem[rd_ptr];

  // NOTE: storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      overflow <= sample_valid && !sample_ready;
    end
  end

  always_comb begin
    state_next = state;
    byte_valid = 1'b0;
    byte_data  = SYNC_BYTE;
    pop        = 1'b0;
    case (state)
      ST_IDLE: if (count >= FRAME_CNT) state_next = ST_SYNC;
      ST_SYNC: begin
        byte_valid = 1'b1;
        if (byte_ready) state_next = ST_LEN;
      end
      ST_LEN: begin
        byte_valid = 1'b1;
        byte_data  = LEN_BYTE;
        if (byte_ready) state_next = ST_PAY_HI;
      end
      ST_PAY_HI: begin
        byte_valid = 1'b1;
        byte_data  = head[15:8];
        if (byte_ready) state_next = ST_PAY_LO;
      end
      ST_PAY_LO: begin
        byte_valid = 1'b1;
        byte_data  = head[7:0];
        if (byte_ready) begin
          pop = 1'b1;
          if (sent != LAST_SAMPLE) state_next = ST_PAY_HI;
`ifdef UART_PACKET_TX_CHECKSUM_EN
          else                     state_next = ST_CHK;
`else
          else                     state_next = ST_IDLE;
`endif
        end
      end
`ifdef UART_PACKET_TX_CHECKSUM_EN
      ST_CHK: begin
        byte_valid = 1'b1;
        byte_data  = checksum;
        if (byte_ready) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // busy spans start bit to the serializer's idle cycle that ends the final stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sent  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_SYNC) sent <= '0;
      else if (pop)         sent <= sent + 7'd1;
      if (state == ST_SYNC && byte_ready)      busy <= 1'b1;
      else if (state == ST_IDLE && byte_ready) busy <= 1'b0;
    end
  end

`ifdef UART_PACKET_TX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (byte_valid && byte_ready) begin
      if (state == ST_LEN)                               checksum <= LEN_BYTE;
      else if (state == ST_PAY_HI || state == ST_PAY_LO) checksum <= checksum ^ byte_data;
    end
  end
`endif

  uart_byte_ser #(.BIT_COUNT(BIT_COUNT)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx         (tx)
  );

endmodule
